// File: rtl/ram_access_ctrl_if.sv
// Request / RAM-control bundle between the control unit, the RAM access sequencer and the RAM.
// The master modport is the environment: control unit plus the RAM read-data return path.
interface ram_access_ctrl_if;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic              src_sel;
  logic [DATA_W-1:0] alu_data;
  logic [DATA_W-1:0] port_data;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_wdata_oe;
  logic              ram_cs;
  logic              ram_oe;
  logic              ram_we_stb;
  logic [DATA_W-1:0] rdr;
  logic              rdr_valid;
  logic              busy;
  logic              ack;

  modport master (
    output req, we, addr, src_sel, alu_data, port_data, ram_rdata,
    input  ram_addr, ram_wdata, ram_wdata_oe, ram_cs, ram_oe, ram_we_stb,
           rdr, rdr_valid, busy, ack
  );

  modport slave (
    input  req, we, addr, src_sel, alu_data, port_data, ram_rdata,
    output ram_addr, ram_wdata, ram_wdata_oe, ram_cs, ram_oe, ram_we_stb,
           rdr, rdr_valid, busy, ack
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// RAM access sequencer: runs one load/store at a time, generates RAM control timing
// and captures load data into the RDR.
module ram_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned STB_CYCLES  = 1
) (
  input logic             clk,
  input logic             rst,
  ram_access_ctrl_if.slave bus
);
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DATA_W = 8;
  localparam logic [CNT_W-1:0] STB_LOAD  = CNT_W'(STB_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, ACCESS, CAPTURE, DONE
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic               is_store;
  logic               accept;
  logic               store_next;
  logic               cs_d, oe_d, stb_d, woe_d, ack_d, busy_d;
  logic               cs_q, oe_q, stb_q, woe_q, ack_q, busy_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdr_q;
  logic               rdr_valid_q;

  assign accept = (state == IDLE) && bus.req;

  // State and phase counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Next-state logic; the counter is loaded on entry to STROBE/ACCESS and counts down to zero
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE:    if (bus.req) state_next = SETUP;
      SETUP: begin
        if (is_store) begin
          state_next = STROBE;
          cnt_next   = STB_LOAD;
        end else begin
          state_next = ACCESS;
          cnt_next   = WAIT_LOAD;
        end
      end
      STROBE:  if (cnt == '0) state_next = HOLD;    else cnt_next = cnt - CNT_W'(1);
      HOLD:    state_next = DONE;
      ACCESS:  if (cnt == '0) state_next = CAPTURE; else cnt_next = cnt - CNT_W'(1);
      CAPTURE: state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode from the next state so the registered strobes line up with the state
  always_comb begin
    cs_d   = 1'b0;
    oe_d   = 1'b0;
    stb_d  = 1'b0;
    woe_d  = 1'b0;
    ack_d  = 1'b0;
    busy_d = (state_next != IDLE);
    // SETUP is only entered from IDLE, where the direction has not been latched yet
    store_next = (state == IDLE) ? bus.we : is_store;
    case (state_next)
      SETUP:   begin cs_d = 1'b1; woe_d = store_next; end
      STROBE:  begin cs_d = 1'b1; woe_d = 1'b1; stb_d = 1'b1; end
      HOLD:    begin cs_d = 1'b1; woe_d = 1'b1; end
      ACCESS:  begin cs_d = 1'b1; oe_d = 1'b1; end
      CAPTURE: begin cs_d = 1'b1; oe_d = 1'b1; end
      DONE:    ack_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cs_q   <= 1'b0;
      oe_q   <= 1'b0;
      stb_q  <= 1'b0;
      woe_q  <= 1'b0;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cs_q   <= cs_d;
      oe_q   <= oe_d;
      stb_q  <= stb_d;
      woe_q  <= woe_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
    end
  end

  // Request latch and RDR capture
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      is_store    <= 1'b0;
      rdr_q       <= '0;
      rdr_valid_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q   <= bus.addr;
        is_store <= bus.we;
        wdata_q  <= bus.src_sel ? bus.port_data : bus.alu_data;
        if (!bus.we) rdr_valid_q <= 1'b0;
      end
      if (state == CAPTURE) begin
        rdr_q       <= bus.ram_rdata;
        rdr_valid_q <= 1'b1;
      end
    end
  end

  assign bus.ram_addr     = addr_q;
  assign bus.ram_wdata    = wdata_q;
  assign bus.ram_wdata_oe = woe_q;
  assign bus.ram_cs       = cs_q;
  assign bus.ram_oe       = oe_q;
  assign bus.ram_we_stb   = stb_q;
  assign bus.rdr          = rdr_q;
  assign bus.rdr_valid    = rdr_valid_q;
  assign bus.busy         = busy_q;
  assign bus.ack          = ack_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Scoreboard bench for ram_access_ctrl: dut0 (WAIT=3, STB=1) carries the scoreboarded
// traffic, dut1 (WAIT=1, STB=4) covers default load latency and reset during a strobe.
module tb_ram_access_ctrl;
  localparam int unsigned W0 = 3;
  localparam int unsigned S0 = 1;
  localparam int unsigned W1 = 1;
  localparam int unsigned S1 = 4;

  logic clk  = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  always #5 clk = ~clk;

  ram_access_ctrl_if bus0 ();
  ram_access_ctrl_if bus1 ();

  ram_access_ctrl #(.WAIT_CYCLES(W0), .STB_CYCLES(S0)) dut0 (.clk(clk), .rst(rst0), .bus(bus0));
  ram_access_ctrl #(.WAIT_CYCLES(W1), .STB_CYCLES(S1)) dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  wire [27:0] out0 = {bus0.ram_addr, bus0.ram_wdata, bus0.ram_wdata_oe, bus0.ram_cs, bus0.ram_oe,
                      bus0.ram_we_stb, bus0.rdr, bus0.rdr_valid, bus0.busy, bus0.ack};
  wire [27:0] out1 = {bus1.ram_addr, bus1.ram_wdata, bus1.ram_wdata_oe, bus1.ram_cs, bus1.ram_oe,
                      bus1.ram_we_stb, bus1.rdr, bus1.rdr_valid, bus1.busy, bus1.ack};

  // RAM model for dut0: preloaded word at 5'h1F, written on the strobe
  logic [7:0] mem0 [32];
  always @(posedge clk) begin
    if (rst0) begin
      for (int i = 0; i < 32; i++) mem0[i] = 8'h00;
      mem0[31] = 8'hA7;
    end else if (bus0.ram_we_stb && bus0.ram_wdata_oe) begin
      mem0[bus0.ram_addr] = bus0.ram_wdata;
    end
  end
  assign bus0.ram_rdata = bus0.ram_oe ? mem0[bus0.ram_addr] : 8'h00;
  assign bus1.ram_rdata = bus1.ram_oe ? 8'h6B : 8'h00;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       load;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdr;
    logic       rdr_valid;
    int         lat;
    int         stb_n;
    int         stb_first;
    int         woe_n;
    int         oe_n;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] m_rdr   = 8'h00;
  logic       m_valid = 1'b0;

  task automatic push_store(input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    e.load = 1'b0; e.addr = a; e.wdata = d; e.rdr = m_rdr; e.rdr_valid = m_valid;
    e.lat = 3 + S0; e.stb_n = S0; e.stb_first = 2; e.woe_n = S0 + 2; e.oe_n = 0;
    sb.push_back(e);
  endtask

  task automatic push_load(input logic [4:0] a, input logic [7:0] d);
    exp_t e;
    m_rdr = d; m_valid = 1'b1;
    e.load = 1'b1; e.addr = a; e.wdata = 8'h00; e.rdr = d; e.rdr_valid = 1'b1;
    e.lat = 3 + W0; e.stb_n = 0; e.stb_first = 0; e.woe_n = 0; e.oe_n = W0 + 1;
    sb.push_back(e);
  endtask

  task automatic drive0(input logic w, input logic [4:0] a, input logic s,
                        input logic [7:0] alu, input logic [7:0] prt);
    bus0.req = 1'b1; bus0.we = w; bus0.addr = a; bus0.src_sel = s;
    bus0.alu_data = alu; bus0.port_data = prt;
  endtask

  task automatic wait_ack0(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bus0.ack === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL %s ack_timeout actual=none required=ack within 40 cycles", name);
    end
  endtask

  // Monitor: per-cycle bus invariants plus scoreboard pop on every ACK of dut0
  logic busy_q = 1'b0;
  logic drove  = 1'b0;
  int   cyc = 0, stb_n = 0, stb_first = 0, woe_n = 0, oe_n = 0, quiet = 0;
  exp_t mon_e;
  always @(negedge clk) begin
    if (rst0) begin
      busy_q = 1'b0; drove = 1'b0; quiet = 0;
    end else begin
      check("oe_and_wdata_oe", 32'(bus0.ram_oe & bus0.ram_wdata_oe), 32'd0);
      if (bus0.ram_we_stb)
        check("stb_needs_cs_woe", 32'({bus0.ram_cs, bus0.ram_wdata_oe}), 32'd3);
      if (bus0.ram_oe || bus0.ram_wdata_oe) begin
        if (drove && quiet > 0) check("turnaround_gap_ge2", 32'(quiet >= 2), 32'd1);
        quiet = 0;
        drove = 1'b1;
      end else begin
        quiet++;
      end
      if (bus0.busy && !busy_q) begin
        cyc = 0; stb_n = 0; stb_first = 0; woe_n = 0; oe_n = 0;
      end
      if (bus0.busy) begin
        cyc++;
        if (bus0.ram_we_stb) begin
          stb_n++;
          if (stb_first == 0) stb_first = cyc;
        end
        if (bus0.ram_wdata_oe) woe_n++;
        if (bus0.ram_oe) oe_n++;
      end
      busy_q = bus0.busy;
      if (bus0.ack) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_ack actual=ack required=no ack (scoreboard empty)");
        end else begin
          mon_e = sb.pop_front();
          check("ack_latency", 32'(cyc), 32'(mon_e.lat));
          check("ram_addr", 32'(bus0.ram_addr), 32'(mon_e.addr));
          if (!mon_e.load) check("ram_wdata", 32'(bus0.ram_wdata), 32'(mon_e.wdata));
          check("we_stb_cycles", 32'(stb_n), 32'(mon_e.stb_n));
          check("we_stb_first_cycle", 32'(stb_first), 32'(mon_e.stb_first));
          check("wdata_oe_cycles", 32'(woe_n), 32'(mon_e.woe_n));
          check("oe_cycles", 32'(oe_n), 32'(mon_e.oe_n));
          check("rdr", 32'(bus0.rdr), 32'(mon_e.rdr));
          check("rdr_valid", 32'(bus0.rdr_valid), 32'(mon_e.rdr_valid));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit seen;
    // Reset with live-looking request inputs on both instances
    drive0(1'b1, 5'h13, 1'b1, 8'hE1, 8'h2D);
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 5'h09; bus1.src_sel = 1'b0;
    bus1.alu_data = 8'h5A; bus1.port_data = 8'hA5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out0", 32'(out0), 32'd0);
    check("reset_out1", 32'(out1), 32'd0);
    @(negedge clk);
    bus0.req = 1'b0; bus1.req = 1'b0;
    rst0 = 1'b0; rst1 = 1'b0;
    repeat (2) @(negedge clk);

    // Store 5'h0A <- ALU 8'h5C; late input changes must not leak in
    drive0(1'b1, 5'h0A, 1'b0, 8'h5C, 8'h77);
    push_store(5'h0A, 8'h5C);
    @(posedge clk); #1;
    bus0.req = 1'b0; bus0.addr = 5'h01; bus0.alu_data = 8'hFF;
    wait_ack0("store_0a");
    repeat (2) @(negedge clk);

    // Load from the top address
    drive0(1'b0, 5'h1F, 1'b0, 8'h00, 8'h00);
    push_load(5'h1F, 8'hA7);
    @(posedge clk); #1;
    bus0.req = 1'b0; bus0.addr = 5'h02;
    wait_ack0("load_1f");
    repeat (2) @(negedge clk);

    // Back-to-back store (PORT_DATA) then load of the same word, REQ held high
    drive0(1'b1, 5'h05, 1'b1, 8'h00, 8'h3E);
    push_store(5'h05, 8'h3E);
    @(posedge clk); #1;
    bus0.we = 1'b0; bus0.src_sel = 1'b0; bus0.alu_data = 8'hC3;
    push_load(5'h05, 8'h3E);
    wait_ack0("b2b_store");
    @(negedge clk);
    check("b2b_idle_gap", 32'(bus0.busy), 32'd0);
    @(negedge clk);
    check("b2b_reaccept", 32'(bus0.busy), 32'd1);
    bus0.req = 1'b0;
    wait_ack0("b2b_load");
    repeat (2) @(negedge clk);

    // REQ pulse and ADDR change while busy are ignored
    drive0(1'b1, 5'h12, 1'b0, 8'h99, 8'h00);
    push_store(5'h12, 8'h99);
    @(posedge clk); #1;
    bus0.req = 1'b0; bus0.addr = 5'h07; bus0.alu_data = 8'h44;
    @(negedge clk);
    bus0.req = 1'b1;
    @(negedge clk);
    bus0.req = 1'b0;
    wait_ack0("busy_req_ignored");
    repeat (6) @(negedge clk);
    check("single_ack_sb_empty", 32'(sb.size()), 32'd0);

    // dut1: load with WAIT_CYCLES = 1, ACK in the 4th cycle with RDR already updated
    bus1.req = 1'b1; bus1.we = 1'b0; bus1.addr = 5'h03;
    @(posedge clk); #1;
    bus1.req = 1'b0;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (bus1.ack === 1'b1) seen = 1'b1;
    end
    check("d1_load_ack_cycle", 32'(n), 32'(3 + W1));
    check("d1_load_rdr", 32'(bus1.rdr), 32'h6B);
    check("d1_load_rdr_valid", 32'(bus1.rdr_valid), 32'd1);
    repeat (2) @(negedge clk);

    // dut1: store with STB_CYCLES = 4, reset after two strobe cycles
    bus1.req = 1'b1; bus1.we = 1'b1; bus1.addr = 5'h04; bus1.alu_data = 8'h11;
    @(posedge clk); #1;
    bus1.req = 1'b0;
    n = 0;
    for (int i = 0; i < 10 && n < 2; i++) begin
      @(negedge clk);
      if (bus1.ram_we_stb === 1'b1) n++;
    end
    check("d1_strobe_seen", 32'(n), 32'd2);
    rst1 = 1'b1;
    @(posedge clk); #1;
    check("d1_rst_mid_strobe", 32'(out1), 32'd0);
    @(posedge clk); #1;
    check("d1_rst_hold", 32'(out1), 32'd0);
    @(negedge clk);
    rst1 = 1'b0;
    repeat (S1 + 3) begin
      @(negedge clk);
      check("d1_no_ack_after_rst", 32'({bus1.ack, bus1.busy, bus1.ram_we_stb}), 32'd0);
    end

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_access_ctrl.md
Name: ram_access_ctrl

Overview:
Sequencer directly upstream of the system RAM / RDR stage.
- Accepts one decoded load/store request at a time from the control unit.
- Generates the RAM control timing: chip select, output enable, write strobe, 5-bit address, and write data with its bus-drive enable.
- On a load, captures the returned RAM data into the RAM Data Register (RDR).
- Guarantees that write-drive and RAM output-enable are never active together.

Parameters:
WAIT_CYCLES, 1, number of cycles RAM_OE is held before read data is captured; legal range 1..15.
STB_CYCLES, 1, write-strobe width in cycles; legal range 1..15.

Ports:
CLK  in  1  system clock; all state changes on rising edge
RST  in  1  synchronous reset, active-high
REQ  in  1  access request; sampled only in IDLE
WE  in  1  1 = store, 0 = load; latched with REQ
ADDR  in  5  RAM word address; latched with REQ
SRC_SEL  in  1  store data source: 0 = ALU_DATA, 1 = PORT_DATA; latched with REQ
ALU_DATA  in  8  ALU result
PORT_DATA  in  8  port-pin read value
RAM_RDATA  in  8  data returned by RAM while RAM_OE is high
RAM_ADDR  out  5  registered RAM address
RAM_WDATA  out  8  registered store data
RAM_WDATA_OE  out  1  enable for the top-level tri-state driver of RAM_WDATA onto the RAM data bus
RAM_CS  out  1  RAM chip select
RAM_OE  out  1  RAM output enable
RAM_WE_STB  out  1  RAM write strobe
RDR  out  8  RAM Data Register
RDR_VALID  out  1  RDR holds data from the most recent completed load
BUSY  out  1  high in every state except IDLE
ACK  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock (CLK). Reset (RST) is synchronous and active-high.
- Reset values: state IDLE; every output 0, including RDR = 8'h00 and RDR_VALID = 0.
- Reset mid-operation: RST overrides all state. On the cycle after the reset edge, all strobes and enables are 0 and no ACK is issued.
- States: IDLE, SETUP, STROBE, HOLD, ACCESS, CAPTURE, DONE. A 4-bit counter times STROBE and ACCESS.
- IDLE:
  - Outputs CS/OE/WE_STB/WDATA_OE = 0.
  - When REQ = 1 at an edge (accept edge E0): latch ADDR into RAM_ADDR, latch WE, and latch the SRC_SEL-selected data into RAM_WDATA; go to SETUP.
  - On a load accept, clear RDR_VALID.
- SETUP (1 cycle): CS = 1. Store: WDATA_OE = 1, then go to STROBE. Load: go to ACCESS.
- STROBE (STB_CYCLES cycles): CS = 1, WDATA_OE = 1, WE_STB = 1. Then go to HOLD.
- HOLD (1 cycle): CS = 1, WDATA_OE = 1, WE_STB = 0. Provides data hold after the strobe falls. Then go to DONE.
- ACCESS (WAIT_CYCLES cycles): CS = 1, OE = 1. Then go to CAPTURE.
- CAPTURE (1 cycle): CS = 1, OE = 1. At the exit edge, RDR <= RAM_RDATA and RDR_VALID <= 1. Then go to DONE.
- DONE (1 cycle): ACK = 1, CS/OE/WE_STB/WDATA_OE = 0. Then go to IDLE.
- Latency with default parameters: ACK is high during the 4th cycle after E0, for both loads and stores.
  - Store: accept-to-ACK latency = 3 + STB_CYCLES cycles.
  - Load: accept-to-ACK latency = 3 + WAIT_CYCLES cycles.
  - On a load, RDR is already updated when ACK is high.
- Handshake:
  - REQ is ignored while BUSY = 1; there is no queueing.
  - A REQ still high in the IDLE cycle following DONE starts a new access. Minimum spacing between accept edges is therefore latency + 1 cycles.
- Bus-contention rules (invariants):
  - RAM_OE and RAM_WDATA_OE are never both 1.
  - WE_STB = 1 implies CS = 1 and WDATA_OE = 1.
  - Back-to-back write→read or read→write always has ≥2 cycles with both OE and WDATA_OE low (DONE + IDLE).
- Data stability: RAM_ADDR and RAM_WDATA change only at accept edges. Changes on ADDR, ALU_DATA or PORT_DATA after acceptance have no effect.
- RDR persistence: RDR and RDR_VALID are unchanged by stores. RDR is overwritten only at CAPTURE.
- Address wrap: ADDR is 5 bits; 5'h1F is a legal address, with no increment logic.

Test Plan:
- Reset: assert RST for 2 cycles from random state → all outputs 0, RDR = 8'h00, BUSY = 0.
- Store: ADDR = 5'h0A, WE = 1, SRC_SEL = 0, ALU_DATA = 8'h5C, default parameters.
  - WE_STB high exactly 1 cycle (the 2nd cycle after E0).
  - RAM_WDATA = 8'h5C and RAM_WDATA_OE high for 3 cycles.
  - ACK pulse in the 4th cycle; RDR unchanged.
- Load: memory model returns 8'hA7 at ADDR = 5'h1F, WAIT_CYCLES = 3 → OE high 4 cycles, RDR = 8'hA7 and RDR_VALID = 1 when ACK rises at cycle 6.
- Back-to-back store then load with REQ held high:
  - Second access accepted in the IDLE cycle after DONE.
  - Checker confirms no cycle with OE and WDATA_OE both 1.
  - SRC_SEL = 1 stores the PORT_DATA value 8'h3E.
- REQ pulse during BUSY and ADDR change after accept → ignored; RAM_ADDR holds the original value; exactly one ACK.
- RST asserted during STROBE (STB_CYCLES = 4) → next cycle WE_STB = 0, CS = 0, no ACK, RDR cleared, BUSY = 0.
